// File: rtl/data_ram_ctrl.sv
// Word-addressed 32-bit RAM behind a ce/we request port with programmable wait states.
// Latency: WAIT_CYCLES+1 cycles from request capture to the one-cycle mem_ready_o strobe.
// Backpressure: requester holds mem_ce_i until mem_ready_o; no new capture until back in IDLE.
module data_ram_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:2] r_addr;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic        r_ready;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic                  w_access;
  logic                  w_acc_we;
  logic [31:2]           w_acc_addr;
  logic [3:0]            w_acc_sel;
  logic [31:0]           w_acc_wdata;
  logic                  w_oor;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_commit;
  logic [31:0]           w_resp_data;
  logic                  w_unused;

  // Byte offset bits are irrelevant for word access.
  assign w_unused = &{1'b0, mem_addr_i[1:0]};

  // With zero wait states the access happens on the capture edge itself, so the
  // live inputs are used there; otherwise the captured copy drives the access.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_sel   = r_sel;
    w_acc_wdata = r_wdata;
    w_access    = (r_state == S_WAIT) && (r_cnt == 4'd1);
    if (r_state == S_IDLE) begin
      w_acc_we    = mem_we_i;
      w_acc_addr  = mem_addr_i[31:2];
      w_acc_sel   = mem_sel_i;
      w_acc_wdata = mem_data_i;
      w_access    = mem_ce_i && (WAIT_LD == 4'd0);
    end
    w_oor       = |w_acc_addr[31:DEPTH_LOG2+2];
    w_idx       = w_acc_addr[DEPTH_LOG2+1:2];
    // rst gate keeps a held request from writing while reset is asserted.
    w_commit    = rst && w_access && w_acc_we && !w_oor;
    w_resp_data = (w_oor || w_acc_we) ? 32'd0 : r_mem[w_idx];
  end

  // Request sequencing and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (mem_ce_i) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i[31:2];
            r_sel   <= mem_sel_i;
            r_wdata <= mem_data_i;
            r_cnt   <= WAIT_LD;
            r_busy  <= 1'b1;
            if (WAIT_LD == 4'd0) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= w_oor;
              r_data  <= w_resp_data;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= w_oor;
            r_data  <= w_resp_data;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: lane-masked write on the edge entering RESP; never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_sel[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  assign mem_data_o  = r_data;
  assign mem_ready_o = r_ready;
  assign mem_err_o   = r_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: two instances (2 and 0 wait states) against a
// transaction-level model (cycles-to-completion plus a word array), with
// directed scenarios and literal expectations.
module tb_data_ram_ctrl;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce   [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];
  logic        bsy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
    .mem_sel_i(sel[0]), .mem_data_i(wdat[0]), .mem_data_o(rdat[0]),
    .mem_ready_o(rdy[0]), .mem_err_o(err[0]), .busy_o(bsy[0]));

  data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
    .mem_sel_i(sel[1]), .mem_data_i(wdat[1]), .mem_data_o(rdat[1]),
    .mem_ready_o(rdy[1]), .mem_err_o(err[1]), .busy_o(bsy[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int          left  [2] = '{0, 0};   // cycles until the access completes (1 = response cycle)
  logic        q_we  [2];
  logic [31:0] q_addr[2];
  logic [3:0]  q_sel [2];
  logic [31:0] q_dat [2];
  logic        e_rdy [2] = '{1'b0, 1'b0};
  logic        e_err [2] = '{1'b0, 1'b0};
  logic        e_bsy [2] = '{1'b0, 1'b0};
  logic [31:0] e_dat [2] = '{32'd0, 32'd0};
  logic [31:0] m_mem [2][1024];

  task automatic model_access(input int k);
    logic oor;
    int   idx;
    oor = (q_addr[k] >= 32'h0000_1000);   // 1024 words = 4 KiB of byte space
    idx = int'(q_addr[k] / 4) % 1024;
    e_err[k] = oor;
    if (oor) begin
      e_dat[k] = 32'd0;
    end else if (q_we[k]) begin
      for (int b = 0; b < 4; b++)
        if (q_sel[k][b]) m_mem[k][idx][8*b +: 8] = q_dat[k][8*b +: 8];
      e_dat[k] = 32'd0;
    end else begin
      e_dat[k] = m_mem[k][idx];
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        left[k] = 0; e_rdy[k] = 0; e_err[k] = 0; e_bsy[k] = 0; e_dat[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_err[k] = 1'b0;
        if (left[k] == 1) begin
          left[k] = 0;
        end else if (left[k] > 1) begin
          left[k]--;
          if (left[k] == 1) model_access(k);
        end else if (ce[k]) begin
          q_we[k] = we[k]; q_addr[k] = addr[k]; q_sel[k] = sel[k]; q_dat[k] = wdat[k];
          left[k] = ((k == 0) ? W0 : W1) + 1;
          if (left[k] == 1) model_access(k);
        end
        e_rdy[k] = (left[k] == 1);
        e_bsy[k] = (left[k] > 0);
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cyc_rdy%0d", k), 32'(rdy[k]), 32'(e_rdy[k]));
      chk($sformatf("cyc_err%0d", k), 32'(err[k]), 32'(e_err[k]));
      chk($sformatf("cyc_bsy%0d", k), 32'(bsy[k]), 32'(e_bsy[k]));
      chk($sformatf("cyc_dat%0d", k), rdat[k], e_dat[k]);
    end
  end

  // ---------------- stimulus ----------------
  // One access; starts from an idle cycle, returns at the negedge where ready is seen.
  task automatic req(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdat[k] = d;
    lat = 0;
    for (int i = 0; i < 20 && !(lat > 0 && rdy[k]); i++) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("done%0d", k), 32'(rdy[k]), 32'd1);
    ce[k] = 1'b0;
    rd = rdat[k];
    er = err[k];
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int k = 0; k < 2; k++) begin
      ce[k] = 0; we[k] = 0; addr[k] = 0; sel[k] = 0; wdat[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy[0]), 32'd0);
    chk("rst_bsy", 32'(bsy[0]), 32'd0);
    chk("rst_dat", rdat[0], 32'd0);
    rst = 1'b1;

    // Full write then read.
    req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    chk("wr_lat", lat, 32'd3);
    chk("wr_dat", rd, 32'd0);
    req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    chk("rd_lat", lat, 32'd3);
    chk("rd_dat", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);
    repeat (2) @(negedge clk);
    chk("hold_dat", rdat[0], 32'hDEADBEEF);

    // Partial write and empty-mask write.
    req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, er, lat);
    req(0, 1'b1, 32'h20, 4'b0100, 32'h00AB0000, rd, er, lat);
    req(0, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    chk("part_dat", rd, 32'h11AB3344);
    req(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    req(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat);
    chk("sel0_dat", rd, 32'h11AB3344);

    // Out of range: no aliasing onto word 0.
    req(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, rd, er, lat);
    req(0, 1'b1, 32'h00001000, 4'hF, 32'h12345678, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_dat", rd, 32'd0);
    req(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat);
    chk("alias_dat", rd, 32'hCAFEF00D);
    chk("alias_err", 32'(er), 32'd0);

    // Inputs changed and ce dropped during WAIT.
    req(0, 1'b1, 32'h44, 4'hF, 32'h13579BDF, rd, er, lat);
    @(negedge clk);
    ce[0] = 1; we[0] = 1; addr[0] = 32'h40; sel[0] = 4'hF; wdat[0] = 32'hA5A5A5A5;
    @(negedge clk);
    ce[0] = 0; we[0] = 0; addr[0] = 32'h44; sel[0] = 4'h0; wdat[0] = 32'h0;
    lat = 1;
    for (int i = 0; i < 20 && !rdy[0]; i++) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_lat", lat, 32'd3);
    req(0, 1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat);
    chk("mid_dat40", rd, 32'hA5A5A5A5);
    req(0, 1'b0, 32'h44, 4'hF, 32'h0, rd, er, lat);
    chk("mid_dat44", rd, 32'h13579BDF);

    // Reset during WAIT aborts the write.
    req(0, 1'b1, 32'h30, 4'hF, 32'h01020304, rd, er, lat);
    req(0, 1'b0, 32'h30, 4'hF, 32'h0, rd, er, lat);   // leaves a nonzero data_o
    @(negedge clk);
    ce[0] = 1; we[0] = 1; addr[0] = 32'h30; sel[0] = 4'hF; wdat[0] = 32'hFFFFFFFF;
    @(negedge clk);
    #2 rst = 1'b0;
    ce[0] = 0;
    #1;
    chk("rstw_bsy", 32'(bsy[0]), 32'd0);
    chk("rstw_dat", rdat[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(0, 1'b0, 32'h30, 4'hF, 32'h0, rd, er, lat);
    chk("rstw_old", rd, 32'h01020304);

    // Reset during RESP keeps the committed write.
    req(0, 1'b1, 32'h50, 4'hF, 32'h55667788, rd, er, lat);
    #2 rst = 1'b0;
    #1;
    chk("rstr_rdy", 32'(rdy[0]), 32'd0);
    chk("rstr_bsy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(0, 1'b0, 32'h50, 4'hF, 32'h0, rd, er, lat);
    chk("rstr_kept", rd, 32'h55667788);

    // Zero wait states: back-to-back reads with ce held.
    req(1, 1'b1, 32'h8, 4'hF, 32'h0BADF00D, rd, er, lat);
    chk("w0_lat", lat, 32'd1);
    @(negedge clk);
    ce[1] = 1; we[1] = 0; addr[1] = 32'h8; sel[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_rdy%0d", i), 32'(rdy[1]), 32'(i % 2 == 0));
      chk($sformatf("b2b_bsy%0d", i), 32'(bsy[1]), 32'(i % 2 == 0));
      if (i % 2 == 0) chk($sformatf("b2b_dat%0d", i), rdat[1], 32'h0BADF00D);
    end
    ce[1] = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_ram_ctrl.md
DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: the SHALL-be storage depth is 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: added wait states per access, legal range 0..15.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 mem_ce_i  in  1  request valid, held by the requester until mem_ready_o.
REQ-006 mem_we_i  in  1  1 = write, 0 = read.
REQ-007 mem_addr_i  in  32  byte address; bits [1:0] are ignored (word access).
REQ-008 mem_sel_i  in  4  byte-lane enables; big-endian: sel[3] selects bits 31:24 (byte offset 0), sel[0] selects bits 7:0 (offset 3).
REQ-009 mem_data_i  in  32  write data, lane-aligned.
REQ-010 mem_data_o  out  32  read data, full word, registered.
REQ-011 mem_ready_o  out  1  one-cycle completion strobe.
REQ-012 mem_err_o  out  1  out-of-range flag, valid with mem_ready_o.
REQ-013 busy_o  out  1  high while a request is captured and not yet completed.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 In IDLE with mem_ce_i=1, the next edge SHALL capture we/addr/sel/data, load the wait counter with WAIT_CYCLES, and move to WAIT; if WAIT_CYCLES=0, it moves directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where it is 1, the FSM SHALL move to RESP.
REQ-017 The memory access SHALL be performed on the edge entering RESP.
REQ-018 Latency SHALL be WAIT_CYCLES+1 cycles from the capture edge to mem_ready_o=1.
REQ-019 In RESP, mem_ready_o SHALL be 1 for exactly one cycle; the FSM then SHALL return to IDLE unconditionally.
REQ-020 A new request SHALL be accepted no earlier than the cycle after RESP, giving a minimum spacing of WAIT_CYCLES+2 cycles per access.
REQ-021 Captured request fields SHALL be used; changes to mem_*_i or a deassertion of mem_ce_i during WAIT or RESP SHALL have no effect on the in-flight access.
REQ-022 On a write, only lanes with sel=1 SHALL be updated; sel=0000 SHALL leave the word unchanged.
REQ-023 On a write, mem_data_o SHALL be 0 in RESP.
REQ-024 On a read, the full stored word SHALL be returned in mem_data_o in RESP, regardless of sel.
REQ-025 Word index SHALL be addr[DEPTH_LOG2+1:2].
REQ-026 If addr[31:DEPTH_LOG2+2] is nonzero, the access is out of range: there SHALL be no write, mem_data_o SHALL be 0, and mem_err_o SHALL be 1 during RESP.
REQ-027 mem_err_o SHALL be 0 at all times other than an out-of-range RESP cycle.
REQ-028 mem_data_o SHALL hold its RESP value until the next RESP cycle or reset.
REQ-029 busy_o SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-030 While rst=0, the FSM SHALL be IDLE; mem_ready_o, mem_err_o and busy_o SHALL be 0; mem_data_o and the wait counter SHALL be 0.
REQ-031 Reset asserted during WAIT SHALL abort the access, with no memory write committed.
REQ-032 Reset asserted in RESP SHALL force mem_ready_o to 0 immediately; a write already committed on entry to RESP SHALL be retained.
REQ-033 Storage contents SHALL NOT be cleared by reset.
REQ-034 The first request SHALL be accepted no earlier than the first rising edge after rst returns to 1.

Verification
REQ-035 Scenario, full write then read: WAIT_CYCLES=2, write addr 0x10, sel 1111, data 0xDEADBEEF, then read addr 0x10 -> each ready arrives 3 cycles after capture, and the read returns 0xDEADBEEF with err=0.
REQ-036 Scenario, partial write: over word 0x11223344 at addr 0x20, write sel 0100, data 0x00AB0000 -> a read returns 0x11AB3344; then write sel 0000 -> the word is unchanged.
REQ-037 Scenario, out of range: DEPTH_LOG2=10, write to addr 0x00001000 -> ready=1, err=1, data_o=0, and a read of addr 0x0 shows no aliasing write.
REQ-038 Scenario, mid-access changes: change addr and drop mem_ce_i during WAIT -> the original captured access completes, and ready arrives on schedule.
REQ-039 Scenario, reset in WAIT: assert rst=0 during WAIT of a write to 0x30 -> outputs go to 0 immediately, and a later read of 0x30 returns the old value.
REQ-040 Scenario, zero wait states: WAIT_CYCLES=0, back-to-back reads with mem_ce_i held high -> ready pulses every 2 cycles, and busy_o toggles IDLE/RESP.
